// File: rtl/vTPU_pkg.sv
// Shared vTPU geometry constants plus the vector register file row/beat types.
// VREG_* names alias the legacy geometry so new blocks can be parameterised from them.
package vTPU_pkg;

    localparam int BITWIDTH             = 8;
    localparam int NUM_REGS             = 8;
    localparam int NUM_REG_ROWS         = 16;
    localparam int NUM_REG_COLUMNS      = 64;
    localparam int META_DATA_SIZE       = 2;
    localparam int NUM_META_REG_COLUMNS = 32;

    localparam int VREG_NUM_REGS  = NUM_REGS;
    localparam int VREG_NUM_ROWS  = NUM_REG_ROWS;
    localparam int VREG_ROW_BYTES = NUM_REG_COLUMNS;
    localparam int VREG_META_BITS = META_DATA_SIZE;
    localparam int VREG_META_COLS = NUM_META_REG_COLUMNS;
    localparam int VREG_BITWIDTH  = BITWIDTH;

    localparam int VREG_DW   = VREG_ROW_BYTES * VREG_BITWIDTH;
    localparam int VREG_MW   = VREG_META_COLS * VREG_META_BITS;
    localparam int VREG_ROWW = $clog2(VREG_NUM_ROWS);

    typedef logic [VREG_DW-1:0] vreg_row_t;
    typedef logic [VREG_MW-1:0] vreg_meta_t;

    typedef struct packed {
        vreg_row_t              data;
        vreg_meta_t             meta;
        logic [VREG_ROWW-1:0]   row;
        logic                   last;
    } vreg_beat_t;

    typedef enum logic [1:0] {
        VREG_IDLE,
        VREG_STREAM,
        VREG_DRAIN
    } vreg_state_t;

    // Register indices are carried in $clog2-wide fields, so non-power-of-two
    // register counts leave encodings that must be rejected.
    function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned limit);
        return idx < limit;
    endfunction

endpackage

// File: rtl/vtpu_skid_buffer.sv
// Two-entry valid/ready FIFO with synchronous flush; holds row beats between
// a producer with one cycle of latency and a consumer that may stall.
module vtpu_skid_buffer
    import vTPU_pkg::*;
#(
    parameter int WIDTH = $bits(vreg_beat_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign in_ready  = (count_q != 2'd2) || out_ready;
    assign out_valid = (count_q != 2'd0);
    assign empty     = (count_q == 2'd0);
    assign out_data  = slot_q[rd_ptr_q];
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vtpu_sparse_vreg_file.sv
// Vector register file with N:M sparsity metadata per row and a command-driven
// row streaming engine feeding the systolic array under valid/ready backpressure.
module vtpu_sparse_vreg_file
    import vTPU_pkg::*;
#(
    parameter int  NUM_REGS  = VREG_NUM_REGS,
    parameter int  NUM_ROWS  = VREG_NUM_ROWS,
    parameter int  ROW_BYTES = VREG_ROW_BYTES,
    parameter int  BITWIDTH  = VREG_BITWIDTH,
    parameter int  META_BITS = VREG_META_BITS,
    parameter int  META_COLS = VREG_META_COLS,
    localparam int RW        = $clog2(NUM_REGS),
    localparam int ROWW      = $clog2(NUM_ROWS),
    localparam int DW        = ROW_BYTES * BITWIDTH,
    localparam int MW        = META_COLS * META_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_reg,
    input  logic [ROWW-1:0] wr_row,
    input  logic [DW-1:0]   wr_data,
    input  logic [MW-1:0]   wr_meta,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [RW-1:0]   cmd_reg,
    input  logic [ROWW-1:0] cmd_row_start,
    input  logic [ROWW-1:0] cmd_row_count,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [MW-1:0]   out_meta,
    output logic [ROWW-1:0] out_row,
    output logic            out_last,
    output logic            cmd_err
);

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [MW-1:0]   meta;
        logic [ROWW-1:0] row;
        logic            last;
    } beat_t;

    localparam int BW = $bits(beat_t);

    logic [DW-1:0] data_mem [NUM_REGS][NUM_ROWS];
    logic [MW-1:0] meta_mem [NUM_REGS][NUM_ROWS];

    vreg_state_t     state_q, state_d;
    logic [RW-1:0]   reg_q, reg_d;
    logic [ROWW-1:0] ptr_q, ptr_d;
    logic [ROWW:0]   rem_q, rem_d;
    logic            cmd_err_q, cmd_err_d;

    logic            wr_ok;
    logic            cmd_ok;
    logic            fwd;
    logic            issue;
    logic            buf_in_ready;
    logic            buf_empty;
    beat_t           rd_beat;
    beat_t           head_beat;

    assign wr_ok  = idx_in_range(32'(wr_reg), NUM_REGS);
    assign cmd_ok = idx_in_range(32'(cmd_reg), NUM_REGS);

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            data_mem[wr_reg][wr_row] <= wr_data;
            meta_mem[wr_reg][wr_row] <= wr_meta;
        end
    end

    // Write-first: a same-cycle write to the row being issued is what the beat carries.
    assign fwd = wr_en && wr_ok && (wr_reg == reg_q) && (wr_row == ptr_q);

    always_comb begin
        rd_beat.data = fwd ? wr_data : data_mem[reg_q][ptr_q];
        rd_beat.meta = fwd ? wr_meta : meta_mem[reg_q][ptr_q];
        rd_beat.row  = ptr_q;
        rd_beat.last = (rem_q == (ROWW+1)'(1));
    end

    always_comb begin
        state_d   = state_q;
        reg_d     = reg_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        cmd_err_d = 1'b0;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        case (state_q)
            VREG_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !flush) begin
                    if (cmd_ok) begin
                        reg_d   = cmd_reg;
                        ptr_d   = cmd_row_start;
                        rem_d   = (cmd_row_count == '0) ? (ROWW+1)'(NUM_ROWS)
                                                        : {1'b0, cmd_row_count};
                        state_d = VREG_STREAM;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            VREG_STREAM: begin
                issue = buf_in_ready && !flush;
                if (issue) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rd_beat.last) begin
                        state_d = VREG_DRAIN;
                    end
                end
            end
            VREG_DRAIN: begin
                if (buf_empty) begin
                    state_d = VREG_IDLE;
                end
            end
            default: state_d = VREG_IDLE;
        endcase
        if (flush) begin
            state_d = VREG_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= VREG_IDLE;
            reg_q     <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_q     <= reg_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign cmd_err = cmd_err_q;

    vtpu_skid_buffer #(
        .WIDTH(BW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (issue),
        .in_ready  (buf_in_ready),
        .in_data   (rd_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_beat),
        .empty     (buf_empty)
    );

    assign out_data = head_beat.data;
    assign out_meta = head_beat.meta;
    assign out_row  = head_beat.row;
    assign out_last = head_beat.last;

endmodule

// File: tb/tb_vtpu_sparse_vreg_file.sv
// Directed bench for the sparse vector register file: a shadow model of the
// storage predicts each streamed beat, queued at command time and popped on transfer.
module tb_vtpu_sparse_vreg_file;

    // Seven registers leave encoding 7 free to exercise the rejected-command path.
    localparam int TB_REGS = 7;
    localparam int TB_ROWS = 16;
    localparam int DW      = 512;
    localparam int MW      = 64;
    localparam int BUDGET  = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [2:0]    wr_reg;
    logic [3:0]    wr_row;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_meta;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_reg;
    logic [3:0]    cmd_row_start;
    logic [3:0]    cmd_row_count;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [MW-1:0] out_meta;
    logic [3:0]    out_row;
    logic          out_last;
    logic          cmd_err;

    typedef struct {
        logic [DW-1:0] data;
        logic [MW-1:0] meta;
        logic [3:0]    row;
        logic          last;
    } exp_beat_t;

    exp_beat_t     sb[$];
    logic [DW-1:0] model_data [TB_REGS][TB_ROWS];
    logic [MW-1:0] model_meta [TB_REGS][TB_ROWS];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    vtpu_sparse_vreg_file #(
        .NUM_REGS(TB_REGS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_reg        (wr_reg),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .wr_meta       (wr_meta),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_reg       (cmd_reg),
        .cmd_row_start (cmd_row_start),
        .cmd_row_count (cmd_row_count),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_meta      (out_meta),
        .out_row       (out_row),
        .out_last      (out_last),
        .cmd_err       (cmd_err)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle row write; the shadow model only follows writes the DUT should keep.
    task automatic applyStimulus(input int r, input int row, input logic [DW-1:0] data,
                                 input logic [MW-1:0] meta);
        wr_en   = 1'b1;
        wr_reg  = 3'(r);
        wr_row  = 4'(row);
        wr_data = data;
        wr_meta = meta;
        @(negedge clk);
        wr_en = 1'b0;
        if (r < TB_REGS) begin
            model_data[r][row] = data;
            model_meta[r][row] = meta;
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready follows 1,0,0,1 repeating.
    task automatic run_stream(input int r, input int start, input int cnt, input int mode,
                              input int coll_cycle, input int coll_row,
                              input logic [DW-1:0] coll_data, input logic [MW-1:0] coll_meta,
                              input int flush_beat);
        int n;
        int first_valid;
        int last_xfer;
        int xfers;
        bit flushed;
        n = (cnt == 0) ? TB_ROWS : cnt;
        sb.delete();
        for (int k = 0; k < n; k++) begin
            exp_beat_t b;
            int row;
            row    = (start + k) % TB_ROWS;
            b.data = (coll_cycle > 0 && row == coll_row) ? coll_data : model_data[r][row];
            b.meta = (coll_cycle > 0 && row == coll_row) ? coll_meta : model_meta[r][row];
            b.row  = 4'(row);
            b.last = (k == n - 1);
            sb.push_back(b);
        end
        checkOutput("cmd_ready_idle", DW'(cmd_ready), DW'(1));
        cmd_valid     = 1'b1;
        cmd_reg       = 3'(r);
        cmd_row_start = 4'(start);
        cmd_row_count = 4'(cnt);
        first_valid   = 0;
        last_xfer     = 0;
        xfers         = 0;
        flushed       = 1'b0;
        for (int i = 1; i <= BUDGET && sb.size() > 0 && !flushed; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            flush     = 1'b0;
            if (i == coll_cycle) begin
                wr_en   = 1'b1;
                wr_reg  = 3'(r);
                wr_row  = 4'(coll_row);
                wr_data = coll_data;
                wr_meta = coll_meta;
                model_data[r][coll_row] = coll_data;
                model_meta[r][coll_row] = coll_meta;
            end else begin
                wr_en = 1'b0;
            end
            out_ready = (mode == 0) || (i % 4 == 1) || (i % 4 == 0);
            #1;
            if (out_valid) begin
                if (first_valid == 0) first_valid = i;
                if (flush_beat > 0 && xfers == flush_beat - 1) begin
                    checkOutput("flush_beat_row", DW'(out_row), DW'(sb[0].row));
                    flush     = 1'b1;
                    out_ready = 1'b0;
                    sb.delete();
                    flushed   = 1'b1;
                end else begin
                    checkOutput("beat_data", out_data, sb[0].data);
                    checkOutput("beat_meta", DW'(out_meta), DW'(sb[0].meta));
                    checkOutput("beat_row", DW'(out_row), DW'(sb[0].row));
                    checkOutput("beat_last", DW'(out_last), DW'(sb[0].last));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        xfers++;
                        last_xfer = i;
                    end
                end
            end
        end
        wr_en = 1'b0;
        if (flushed) begin
            @(negedge clk);
            flush     = 1'b0;
            out_ready = 1'b1;
            #1;
            checkOutput("flush_valid_low", DW'(out_valid), DW'(0));
            checkOutput("flush_cmd_ready", DW'(cmd_ready), DW'(1));
        end else begin
            checkOutput("stream_complete", DW'(sb.size()), DW'(0));
            checkOutput("first_valid_latency", DW'(first_valid), DW'(2));
            if (mode == 0) begin
                checkOutput("back_to_back", DW'(last_xfer - first_valid + 1), DW'(n));
            end
            out_ready = 1'b1;
            for (int i = 0; i < 8 && !cmd_ready; i++) begin
                @(negedge clk);
                #1;
            end
            checkOutput("return_idle", DW'(cmd_ready), DW'(1));
            checkOutput("no_extra_beat", DW'(out_valid), DW'(0));
        end
    endtask

    initial begin
        rst           = 1'b1;
        wr_en         = 1'b0;
        wr_reg        = '0;
        wr_row        = '0;
        wr_data       = '0;
        wr_meta       = '0;
        cmd_valid     = 1'b0;
        cmd_reg       = '0;
        cmd_row_start = '0;
        cmd_row_count = '0;
        flush         = 1'b0;
        out_ready     = 1'b1;
        #1;
        checkOutput("rst_cmd_ready", DW'(cmd_ready), DW'(1));
        checkOutput("rst_out_valid", DW'(out_valid), DW'(0));
        checkOutput("rst_out_last", DW'(out_last), DW'(0));
        checkOutput("rst_cmd_err", DW'(cmd_err), DW'(0));
        checkOutput("rst_out_data", out_data, DW'(0));
        checkOutput("rst_out_meta", DW'(out_meta), DW'(0));
        checkOutput("rst_out_row", DW'(out_row), DW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int row = 0; row < TB_ROWS; row++) begin
            applyStimulus(3, row, {64{8'(row)}}, MW'(row));
            applyStimulus(1, row, {64{8'(8'h80 | row)}}, MW'(row * 3 + 1));
            applyStimulus(2, row, {64{8'h55}}, MW'(5));
        end

        $display("[TB] full 16-row stream of reg 3");
        run_stream(3, 0, 0, 0, 0, 0, '0, '0, 0);
        $display("[TB] wrapping stream reg 1 rows 14..1");
        run_stream(1, 14, 4, 0, 0, 0, '0, '0, 0);
        $display("[TB] wrapping stream with out_ready 1,0,0,1");
        run_stream(1, 14, 4, 1, 0, 0, '0, '0, 0);
        $display("[TB] write/read collision on reg 2 row 5");
        run_stream(2, 4, 3, 0, 2, 5, {64{8'hAA}}, MW'(10), 0);

        $display("[TB] out-of-range command");
        cmd_valid     = 1'b1;
        cmd_reg       = 3'(TB_REGS);
        cmd_row_start = '0;
        cmd_row_count = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checkOutput("err_pulse", DW'(cmd_err), DW'(1));
        checkOutput("err_cmd_ready", DW'(cmd_ready), DW'(1));
        checkOutput("err_no_valid", DW'(out_valid), DW'(0));
        @(negedge clk);
        #1;
        checkOutput("err_one_cycle", DW'(cmd_err), DW'(0));
        checkOutput("err_still_no_valid", DW'(out_valid), DW'(0));
        run_stream(3, 7, 2, 0, 0, 0, '0, '0, 0);

        $display("[TB] flush alongside a command in idle");
        flush         = 1'b1;
        cmd_valid     = 1'b1;
        cmd_reg       = 3'd3;
        cmd_row_start = '0;
        cmd_row_count = '0;
        @(negedge clk);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checkOutput("flush_cmd_not_taken", DW'(cmd_ready), DW'(1));
        @(negedge clk);
        #1;
        checkOutput("flush_cmd_no_beat", DW'(out_valid), DW'(0));

        $display("[TB] flush at third beat, then a fresh command");
        run_stream(3, 0, 0, 0, 0, 0, '0, '0, 3);
        run_stream(1, 3, 2, 0, 0, 0, '0, '0, 0);

        $display("[TB] reset in the middle of a stream");
        cmd_valid     = 1'b1;
        cmd_reg       = 3'd3;
        cmd_row_start = '0;
        cmd_row_count = '0;
        out_ready     = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("pre_reset_valid", DW'(out_valid), DW'(1));
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", DW'(out_valid), DW'(0));
        checkOutput("mid_rst_cmd_ready", DW'(cmd_ready), DW'(1));
        checkOutput("mid_rst_out_data", out_data, DW'(0));
        checkOutput("mid_rst_out_row", DW'(out_row), DW'(0));
        checkOutput("mid_rst_out_last", DW'(out_last), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
